sisc_core_p: RTL and testbench

//  Parametrised multi-cycle SISC execution core: register file, ALU, status register and control FSM in one block.

---
 rtl/sisc_core_p.sv | 185 ++++++++++++++++++
 tb/tb_sisc_core_p.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sisc_core_p.sv
// Multi-cycle SISC core: register file, ALU, {C,V,N,Z} status and FETCH/DECODE/EXECUTE/WRITEBACK control.
// Define SISC_MUL_EN to add mm 8 = unsigned MUL (two EXECUTE cycles); otherwise mm 8 is illegal.
module sisc_core_p #(
  parameter int DW   = 32,
  parameter int NREG = 16
) (
  input  logic          clk,
  input  logic          rst_f,
  input  logic [31:0]   ir,
  input  logic          ir_valid,
  output logic          ir_ready,
  output logic          wb_valid,
  output logic [3:0]    wb_addr,
  output logic [DW-1:0] wb_data,
  output logic [3:0]    stat,
  output logic          halted,
  output logic          err
);
  localparam int         SHW    = $clog2(DW);
  localparam logic [4:0] NREG_L = 5'(NREG);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT} state_t;

  state_t        state_q;
  logic [31:0]   ir_q;
  logic [DW-1:0] opa_q, opb_q;
  logic [DW-1:0] rf_q [NREG];
  logic [3:0]    stat_q, stat_nxt_q;
  logic          wr_en_q, stat_en_q, err_q, ready_q, halted_q, wb_valid_q, mul_wait_q;
  logic [3:0]    wb_addr_q;
  logic [DW-1:0] wb_data_q;

  logic [3:0] op, mm, rd, rs, rt;
  assign op = ir_q[31:28];
  assign mm = ir_q[27:24];
  assign rd = ir_q[23:20];
  assign rs = ir_q[19:16];
  assign rt = ir_q[15:12];

  logic is_alu, op_bad, mm_ok, mul_op, rd_ok, rs_ok, rt_ok, reg_bad, alu_go, exec_hold;
  assign is_alu = (op == 4'd1) || (op == 4'd2);
  assign op_bad = !((op == 4'd0) || is_alu || (op == 4'hF));
  assign rd_ok  = {1'b0, rd} < NREG_L;
  assign rs_ok  = {1'b0, rs} < NREG_L;
  assign rt_ok  = {1'b0, rt} < NREG_L;
  assign reg_bad = !rd_ok || !rs_ok || ((op == 4'd1) && !rt_ok);

`ifdef SISC_MUL_EN
  logic [2*DW-1:0] prod;
  assign prod   = {{DW{1'b0}}, opa_q} * {{DW{1'b0}}, opb_q};
  assign mm_ok  = mm <= 4'd8;
  assign mul_op = mm == 4'd8;
`else
  assign mm_ok  = !mm[3];
  assign mul_op = 1'b0;
`endif

  assign alu_go    = is_alu && mm_ok;
  assign exec_hold = alu_go && mul_op && !mul_wait_q;

  // Indices at or beyond NREG fall through the loop and read as zero, as does r0.
  logic [DW-1:0] rs_val, rt_val, imm_val;
  always_comb begin
    rs_val = '0;
    rt_val = '0;
    for (int i = 1; i < NREG; i++) begin
      if (rs == 4'(i)) rs_val = rf_q[i];
      if (rt == 4'(i)) rt_val = rf_q[i];
    end
    imm_val = DW'({{48{ir_q[15]}}, ir_q[15:0]});
  end

  logic [DW:0]    sum, diff;
  logic [SHW-1:0] shamt;
  logic [DW-1:0]  res_d;
  logic           c_d, v_d;
  always_comb begin
    sum   = {1'b0, opa_q} + {1'b0, opb_q};
    diff  = {1'b0, opa_q} - {1'b0, opb_q};
    shamt = opb_q[SHW-1:0];
    res_d = '0;
    c_d   = 1'b0;
    v_d   = 1'b0;
    case (mm)
      4'd0: begin
        res_d = sum[DW-1:0];
        c_d   = sum[DW];
        v_d   = (opa_q[DW-1] == opb_q[DW-1]) && (res_d[DW-1] != opa_q[DW-1]);
      end
      4'd1: begin
        res_d = diff[DW-1:0];
        c_d   = !diff[DW];
        v_d   = (opa_q[DW-1] != opb_q[DW-1]) && (res_d[DW-1] != opa_q[DW-1]);
      end
      4'd2: res_d = opa_q & opb_q;
      4'd3: res_d = opa_q | opb_q;
      4'd4: res_d = opa_q ^ opb_q;
      4'd5: res_d = ~opa_q;
      4'd6: res_d = opa_q << shamt;
      4'd7: res_d = opa_q >> shamt;
`ifdef SISC_MUL_EN
      4'd8: begin
        res_d = prod[DW-1:0];
        c_d   = |prod[2*DW-1:DW];
      end
`endif
      default: res_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_f) begin
      state_q    <= S_FETCH;
      ir_q       <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      stat_q     <= '0;
      stat_nxt_q <= '0;
      wr_en_q    <= 1'b0;
      stat_en_q  <= 1'b0;
      err_q      <= 1'b0;
      ready_q    <= 1'b0;
      halted_q   <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      mul_wait_q <= 1'b0;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (ir_valid && ready_q) begin
            ir_q    <= ir;
            ready_q <= 1'b0;
            state_q <= S_DECODE;
          end else begin
            ready_q <= 1'b1;
          end
        end
        S_DECODE: begin
          opa_q   <= rs_val;
          opb_q   <= (op == 4'd2) ? imm_val : rt_val;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          mul_wait_q <= exec_hold;
          if (!exec_hold) begin
            wb_valid_q <= alu_go && !reg_bad;
            wb_addr_q  <= rd;
            wb_data_q  <= res_d;
            wr_en_q    <= alu_go && !reg_bad && (rd != 4'd0);
            stat_en_q  <= alu_go;
            stat_nxt_q <= {c_d, v_d, res_d[DW-1], res_d == '0};
            if (op_bad || (is_alu && (!mm_ok || reg_bad))) err_q <= 1'b1;
            state_q    <= S_WB;
          end
        end
        S_WB: begin
          wb_valid_q <= 1'b0;
          for (int i = 1; i < NREG; i++) begin
            if (wr_en_q && (rd == 4'(i))) rf_q[i] <= wb_data_q;
          end
          if (stat_en_q) stat_q <= stat_nxt_q;
          if (op == 4'hF) begin
            state_q  <= S_HALT;
            halted_q <= 1'b1;
          end else begin
            state_q <= S_FETCH;
            ready_q <= 1'b1;
          end
        end
        S_HALT: state_q <= S_HALT;
        default: state_q <= S_FETCH;
      endcase
    end
  end

  assign ir_ready = ready_q;
  assign wb_valid = wb_valid_q;
  assign wb_addr  = wb_addr_q;
  assign wb_data  = wb_data_q;
  assign stat     = stat_q;
  assign halted   = halted_q;
  assign err      = err_q;
endmodule

// File: tb/tb_sisc_core_p.sv
// Bench for sisc_core_p: a DW=32/NREG=16 core and a DW=8/NREG=4 core, each checked against an arithmetic reference model.
module tb_sisc_core_p;
  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   [2];
  logic [31:0] irv   [2];
  logic        ivld  [2];
  logic        rdy   [2];
  logic        wbv   [2];
  logic        hlt   [2];
  logic        er    [2];
  logic [3:0]  wba   [2];
  logic [3:0]  st    [2];
  logic [31:0] wbd_a;
  logic [7:0]  wbd_b;

  sisc_core_p #(.DW(32), .NREG(16)) u_dut_a (
    .clk(clk), .rst_f(rst[0]), .ir(irv[0]), .ir_valid(ivld[0]), .ir_ready(rdy[0]),
    .wb_valid(wbv[0]), .wb_addr(wba[0]), .wb_data(wbd_a), .stat(st[0]), .halted(hlt[0]), .err(er[0]));

  sisc_core_p #(.DW(8), .NREG(4)) u_dut_b (
    .clk(clk), .rst_f(rst[1]), .ir(irv[1]), .ir_valid(ivld[1]), .ir_ready(rdy[1]),
    .wb_valid(wbv[1]), .wb_addr(wba[1]), .wb_data(wbd_b), .stat(st[1]), .halted(hlt[1]), .err(er[1]));

  int n_chk = 0;
  int n_err = 0;

  logic [63:0] m_reg [2][16];
  logic [3:0]  m_stat [2];
  bit          m_err  [2];
  bit          m_halt [2];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] wbdat(input int s);
    return (s != 0) ? 64'(wbd_b) : 64'(wbd_a);
  endfunction

  function automatic logic [63:0] rval(input int s, input logic [3:0] idx, input int nreg);
    if (idx == 4'd0 || int'(idx) >= nreg) return 64'd0;
    return m_reg[s][idx];
  endfunction

  task automatic model_clear(input int s);
    for (int k = 0; k < 16; k++) m_reg[s][k] = 64'd0;
    m_stat[s] = 4'd0;
    m_err[s]  = 1'b0;
    m_halt[s] = 1'b0;
  endtask

  task automatic model_exec(input int s, input logic [31:0] i,
                            output bit ev, output logic [3:0] ea, output logic [63:0] ed);
    int dw, nreg, sh;
    logic [63:0] mask, a, b, r, sum;
    logic [3:0] op, mm, rd, rs, rt;
    bit c, v, bad;
    dw   = (s != 0) ? 8 : 32;
    nreg = (s != 0) ? 4 : 16;
    mask = (64'd1 << dw) - 64'd1;
    op = i[31:28]; mm = i[27:24]; rd = i[23:20]; rs = i[19:16]; rt = i[15:12];
    ev = 1'b0; ea = 4'd0; ed = 64'd0;
    if (op == 4'hF) begin
      m_halt[s] = 1'b1;
    end else if (op == 4'd1 || op == 4'd2) begin
      if (mm > 4'd7) begin
        m_err[s] = 1'b1;
      end else begin
        a   = rval(s, rs, nreg);
        b   = (op == 4'd1) ? rval(s, rt, nreg) : (64'($signed(i[15:0])) & mask);
        bad = (int'(rd) >= nreg) || (int'(rs) >= nreg) || (op == 4'd1 && int'(rt) >= nreg);
        c = 1'b0; v = 1'b0; r = 64'd0;
        sh = int'(b % 64'(dw));
        case (mm)
          4'd0: begin
            sum = a + b; r = sum & mask; c = sum[dw];
            v = (a[dw-1] == b[dw-1]) && (r[dw-1] != a[dw-1]);
          end
          4'd1: begin
            r = (a - b) & mask; c = (a >= b);
            v = (a[dw-1] != b[dw-1]) && (r[dw-1] != a[dw-1]);
          end
          4'd2: r = a & b;
          4'd3: r = a | b;
          4'd4: r = a ^ b;
          4'd5: r = ~a & mask;
          4'd6: r = (a << sh) & mask;
          default: r = a >> sh;
        endcase
        m_stat[s] = {c, v, r[dw-1], r == 64'd0};
        if (bad) begin
          m_err[s] = 1'b1;
        end else begin
          ev = 1'b1; ea = rd; ed = r;
          if (rd != 4'd0) m_reg[s][rd] = r;
        end
      end
    end else if (op != 4'd0) begin
      m_err[s] = 1'b1;
    end
  endtask

  task automatic do_reset(input int s);
    rst[s] = 1'b1; ivld[s] = 1'b0;
    @(posedge clk); #1;
    chk("rst_ready", rdy[s], 0);
    chk("rst_wbv", wbv[s], 0);
    chk("rst_wba", wba[s], 0);
    chk("rst_wbd", wbdat(s), 0);
    chk("rst_stat", st[s], 0);
    chk("rst_err", er[s], 0);
    chk("rst_halt", hlt[s], 0);
    rst[s] = 1'b0;
    model_clear(s);
  endtask

  // Handshake one instruction, scribble on ir/ir_valid while busy, then compare everything.
  task automatic issue(input int s, input logic [31:0] instr);
    bit ev; logic [3:0] ea, ga; logic [63:0] ed, gd;
    int n, seen, at; logic rdy_after;
    n = 0;
    while (!rdy[s] && n < 12) begin @(posedge clk); #1; n++; end
    chk("ready_wait", rdy[s], 1);
    model_exec(s, instr, ev, ea, ed);
    irv[s] = instr; ivld[s] = 1'b1;
    @(posedge clk); #1;
    seen = 0; at = 0; ga = 4'd0; gd = 64'd0; rdy_after = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (k <= 2) begin irv[s] = $urandom; ivld[s] = 1'($urandom); end
      else ivld[s] = 1'b0;
      @(posedge clk); #1;
      if (wbv[s]) begin seen++; at = k; ga = wba[s]; gd = wbdat(s); end
      if (k == 3) rdy_after = rdy[s];
    end
    chk("wb_count", 64'(seen), ev ? 64'd1 : 64'd0);
    if (ev) begin
      chk("wb_latency", 64'(at), 2);
      chk("wb_addr", ga, ea);
      chk("wb_data", gd, ed);
    end
    chk("stat", st[s], m_stat[s]);
    chk("err", er[s], m_err[s]);
    chk("halted", hlt[s], m_halt[s]);
    chk("ready_back", rdy_after, !m_halt[s]);
  endtask

  function automatic logic [31:0] rand_instr(input int s);
    logic [3:0] op, mm, rd, rs, rt; logic [15:0] imm; int sel, maxr;
    maxr = (s != 0) ? 5 : 15;
    sel = $urandom_range(0, 11);
    if (sel < 5)       op = 4'd1;
    else if (sel < 10) op = 4'd2;
    else if (sel == 10) op = 4'd0;
    else               op = 4'($urandom_range(3, 14));
    mm = 4'($urandom_range(0, 8));
    rd = 4'($urandom_range(0, maxr));
    rs = 4'($urandom_range(0, maxr));
    rt = 4'($urandom_range(0, maxr));
    if (op == 4'd1) imm = {rt, 12'($urandom)};
    else imm = ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'($urandom_range(0, 40));
    return {op, mm, rd, rs, imm};
  endfunction

  initial begin
    for (int s = 0; s < 2; s++) begin
      rst[s] = 1'b1; irv[s] = 32'd0; ivld[s] = 1'b0; model_clear(s);
    end
    @(posedge clk); #1;

    do_reset(0);
    issue(0, 32'h2010_0005);
    issue(0, 32'h2010_FFFF);
    issue(0, 32'h2711_0001);
    issue(0, 32'h2020_0001);
    issue(0, 32'h1031_2000);
    issue(0, 32'h1131_1000);
    issue(0, 32'h2040_0021);
    issue(0, 32'h2050_0003);
    issue(0, 32'h1665_4000);
    issue(0, 32'h2000_0009);
    issue(0, 32'h1070_0000);
    issue(0, 32'h7123_4567);
    for (int t = 0; t < 80; t++) issue(0, rand_instr(0));

    issue(0, 32'hF000_0000);
    irv[0] = 32'h2010_0003; ivld[0] = 1'b1;
    for (int t = 0; t < 5; t++) begin
      @(posedge clk); #1;
      chk("halt_ready", rdy[0], 0);
      chk("halt_wbv", wbv[0], 0);
    end
    chk("halt_sticky", hlt[0], 1);
    ivld[0] = 1'b0;

    do_reset(0);
    issue(0, 32'h2040_0009);
    while (!rdy[0]) begin @(posedge clk); #1; end
    irv[0] = 32'h2040_0007; ivld[0] = 1'b1;
    @(posedge clk); #1;
    ivld[0] = 1'b0;
    @(posedge clk); #1;
    rst[0] = 1'b1;
    @(posedge clk); #1;
    chk("midrst_wbv", wbv[0], 0);
    rst[0] = 1'b0;
    model_clear(0);
    @(posedge clk); #1;
    chk("midrst_wbv2", wbv[0], 0);
    chk("midrst_ready", rdy[0], 1);
    issue(0, 32'h1054_0000);

    do_reset(1);
    issue(1, 32'h2010_FFFF);
    issue(1, 32'h2011_0001);
    issue(1, 32'h2050_0001);
    for (int t = 0; t < 30; t++) issue(1, rand_instr(1));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
